param_sram_responder: RTL

- Responder end of the accelerator's single-port parameter RAM protocol.
- Accepts read/write requests issued by the accelerator controller and returns read data after a fixed, parameterised latency.
- After every reset it clears its storage to zero before accepting any traffic.
- Sits between the controller's parameter port and the weight/bias storage used by the LOAD and STREAM phases.

---
 rtl/accel_pkg.sv | 32 +++
 rtl/param_rd_pipe.sv | 49 ++++
 rtl/param_sram_responder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: controller and parameter-RAM responder state indices,
// width constants and parameter/parity helper functions.
package accel_pkg;

    localparam int CTRL_STATE_W = 4;
    localparam int CTRL_IDLE    = 0;
    localparam int CTRL_LOAD    = 1;
    localparam int CTRL_STREAM  = 2;
    localparam int CTRL_DONE    = 3;

    localparam int RSP_STATE_W  = 2;
    localparam int S_CLEAR      = 0;
    localparam int S_READY      = 1;

    localparam int RD_LAT_MIN   = 1;
    localparam int RD_LAT_MAX   = 4;

    // One-hot encodings; bit positions match S_CLEAR / S_READY above.
    typedef enum logic [RSP_STATE_W-1:0] {
        ST_CLEAR = 2'b01,
        ST_READY = 2'b10
    } rsp_state_e;

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/param_rd_pipe.sv
// Fixed-latency valid/data delay line; data stages load only with a valid beat so the
// last stage holds the most recent payload. STAGES may be zero (pure wire-through).
module param_rd_pipe #(
    parameter int STAGES = 1,
    parameter int W      = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_stages
            logic [STAGES-1:0] vld_r;
            logic [W-1:0]      data_r [STAGES];

            // Shift valid bits every cycle; advance payload only behind a valid bit.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    vld_r <= '0;
                    for (int i = 0; i < STAGES; i++) begin
                        data_r[i] <= '0;
                    end
                end else begin
                    vld_r[0] <= in_valid;
                    if (in_valid) begin
                        data_r[0] <= in_data;
                    end
                    for (int i = 1; i < STAGES; i++) begin
                        vld_r[i] <= vld_r[i-1];
                        if (vld_r[i-1]) begin
                            data_r[i] <= data_r[i-1];
                        end
                    end
                end
            end

            assign out_valid = vld_r[STAGES-1];
            assign out_data  = data_r[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/param_sram_responder.sv
// Parameter-RAM responder: zero-fills storage after reset, then serves byte-strobed writes
// and fixed-latency reads. Optional per-byte parity via PARAM_RAM_PARITY_EN.
module param_sram_responder
    import accel_pkg::*;
#(
    parameter  int DEPTH  = 256,
    parameter  int DATA_W = 32,
    parameter  int RD_LAT = 2,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef PARAM_RAM_PARITY_EN
    input  logic              inj_parity,
    output logic              parity_err,
`endif
    output logic              init_done
);

`ifdef PARAM_RAM_PARITY_EN
    localparam int PIPE_W = DATA_W + 1;
`else
    localparam int PIPE_W = DATA_W;
`endif

    generate
        if (!rd_lat_ok(RD_LAT) || ((DEPTH & (DEPTH - 1)) != 0) || ((DATA_W % 8) != 0)) begin : g_bad_cfg
            $error("param_sram_responder: illegal DEPTH/DATA_W/RD_LAT configuration");
        end
    endgenerate

    logic [DATA_W-1:0] mem_r [DEPTH];
    rsp_state_e        state_r;
    rsp_state_e        state_s;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic              accept_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [STRB_W-1:0] wr_strb_s;
    logic [PIPE_W-1:0] rd_word_s;
    logic              rd_vld_r;
    logic [PIPE_W-1:0] rd_stage_r;
    logic              pipe_vld_s;
    logic [PIPE_W-1:0] pipe_data_s;

    assign req_ready = state_r[S_READY];
    assign init_done = state_r[S_READY];
    assign accept_s  = req_valid && req_ready;

    // State register and clear-address counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_CLEAR) begin
                clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
            end
        end
    end

    // Next state: clear sweeps every address once, then ready until reset.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == ADDR_W'(DEPTH - 1)) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_READY: state_s = ST_READY;
            default:  state_s = ST_CLEAR;
        endcase
    end

    // Write port mux: zero-fill during clear, strobed request writes when ready.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = req_addr;
        wr_data_s = req_wdata;
        wr_strb_s = req_wstrb;
        case (state_r)
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = clr_cnt_r;
                wr_data_s = '0;
                wr_strb_s = '1;
            end
            ST_READY: wr_en_s = accept_s && req_we;
            default:  wr_en_s = 1'b0;
        endcase
    end

    // Storage array write (not reset; the clear sequence initialises it).
    always_ff @(posedge clk) begin
        if (rstn && wr_en_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb_s[i]) begin
                    mem_r[wr_addr_s][i*8 +: 8] <= wr_data_s[i*8 +: 8];
                end
            end
        end
    end

`ifdef PARAM_RAM_PARITY_EN
    logic [STRB_W-1:0] par_r [DEPTH];
    logic              wr_inj_s;
    logic              rd_perr_s;

    assign wr_inj_s = state_r[S_READY] & inj_parity;

    // Parity array shares the data write enables; inj_parity corrupts the stored bit.
    always_ff @(posedge clk) begin
        if (rstn && wr_en_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb_s[i]) begin
                    par_r[wr_addr_s][i] <= byte_parity(wr_data_s[i*8 +: 8]) ^ wr_inj_s;
                end
            end
        end
    end

    // Any byte whose recomputed parity disagrees with its stored bit flags the word.
    always_comb begin
        rd_perr_s = 1'b0;
        for (int i = 0; i < STRB_W; i++) begin
            rd_perr_s = rd_perr_s | (par_r[req_addr][i] ^ byte_parity(mem_r[req_addr][i*8 +: 8]));
        end
    end

    assign rd_word_s = {rd_perr_s, mem_r[req_addr]};
`else
    assign rd_word_s = mem_r[req_addr];
`endif

    // First read stage: registers the array output for accepted reads.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_vld_r   <= 1'b0;
            rd_stage_r <= '0;
        end else begin
            rd_vld_r <= accept_s && !req_we;
            if (accept_s && !req_we) begin
                rd_stage_r <= rd_word_s;
            end
        end
    end

    param_rd_pipe #(
        .STAGES (RD_LAT - 1),
        .W      (PIPE_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (rd_vld_r),
        .in_data   (rd_stage_r),
        .out_valid (pipe_vld_s),
        .out_data  (pipe_data_s)
    );

    assign rsp_valid = pipe_vld_s;
    assign rsp_rdata = pipe_data_s[DATA_W-1:0];
`ifdef PARAM_RAM_PARITY_EN
    assign parity_err = pipe_vld_s & pipe_data_s[DATA_W];
`endif

endmodule
